// File: rtl/rram_seq_pkg.sv
// rtl/rram_seq_pkg.sv - shared state encodings and defaults for the RRAM access sequencer
//
// Purpose: one-hot state localparams, default phase lengths and a
// configuration helper shared by the sequencer top and its phase timer.
// Ports: none (package).
package rram_seq_pkg;

   localparam int ST_W = 6;

   localparam logic [ST_W-1:0] S_IDLE  = 6'b000001;
   localparam logic [ST_W-1:0] S_PRE   = 6'b000010;
   localparam logic [ST_W-1:0] S_DVLP  = 6'b000100;
   localparam logic [ST_W-1:0] S_SENSE = 6'b001000;
   localparam logic [ST_W-1:0] S_WRITE = 6'b010000;
   localparam logic [ST_W-1:0] S_DONE  = 6'b100000;

   localparam int B_SIZE_DEF  = 4;
   localparam int T_PRE_DEF   = 2;
   localparam int T_DVLP_DEF  = 3;
   localparam int T_SA_DEF    = 2;
   localparam int T_WRITE_DEF = 8;
   localparam int CNT_W_DEF   = 4;

   // A phase length is usable when it is at least one cycle and its
   // reload value (length-1) fits in the counter.
   function automatic bit phase_len_ok(input int t, input int w);
      return (t >= 1) && ((t - 1) < (1 << w));
   endfunction

endpackage

// File: rtl/rram_phase_timer.sv
// rtl/rram_phase_timer.sv - loadable down-counter timing each sequencer phase
//
// Purpose: holds the remaining cycles of the current phase. Load wins over
// decrement; the count saturates at zero.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   load     in   load load_val this edge
//   load_val in   CNT_W value to load (phase length - 1)
//   dec      in   decrement this edge
//   zero     out  count is zero (last cycle of the phase)
module rram_phase_timer
   import rram_seq_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - CNT_W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/rram_access_sequencer.sv
// rtl/rram_access_sequencer.sv - read/write phase sequencer for the RRAM column periphery
//
// Purpose: accepts one access at a time over REQ/ACK, then drives the
// precharge / develop / sense sequence for reads (capturing Z_BUS on the
// edge leaving sense) or a single timed write pulse for writes.
// Ports:
//   CLK, RST    in   clock (rising) and asynchronous active-high reset
//   REQ, WE     in   access request and direction (1=write), sampled in IDLE
//   DIN         in   write data, sampled with REQ
//   Z_BUS       in   sense-amp data from the periphery
//   WDATA       out  registered write data
//   DOUT        out  captured read data
//   ACK, BUSY   out  completion pulse and busy flag
//   WRITE_VDDH, READ_VDDH, PRE_H, DVLP_H, SA_EN_H, dummy_en
//               out  array control lines (all registered)
module rram_access_sequencer
   import rram_seq_pkg::*;
#(
   parameter int B_SIZE  = B_SIZE_DEF,
   parameter int T_PRE   = T_PRE_DEF,
   parameter int T_DVLP  = T_DVLP_DEF,
   parameter int T_SA    = T_SA_DEF,
   parameter int T_WRITE = T_WRITE_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              REQ,
   input  logic              WE,
   input  logic [B_SIZE-1:0] DIN,
   input  logic [B_SIZE-1:0] Z_BUS,
   output logic [B_SIZE-1:0] WDATA,
   output logic [B_SIZE-1:0] DOUT,
   output logic              ACK,
   output logic              BUSY,
   output logic              WRITE_VDDH,
   output logic              READ_VDDH,
   output logic              PRE_H,
   output logic              DVLP_H,
   output logic              SA_EN_H,
   output logic              dummy_en
);

   generate
      if (!(phase_len_ok(T_PRE, CNT_W) && phase_len_ok(T_DVLP, CNT_W) &&
            phase_len_ok(T_SA, CNT_W) && phase_len_ok(T_WRITE, CNT_W))) begin : g_cfg_err
         $error("rram_access_sequencer: a phase length is < 1 or does not fit CNT_W");
      end
   endgenerate

   localparam logic [CNT_W-1:0] LD_PRE   = CNT_W'(T_PRE - 1);
   localparam logic [CNT_W-1:0] LD_DVLP  = CNT_W'(T_DVLP - 1);
   localparam logic [CNT_W-1:0] LD_SA    = CNT_W'(T_SA - 1);
   localparam logic [CNT_W-1:0] LD_WRITE = CNT_W'(T_WRITE - 1);

   logic [ST_W-1:0]  state;
   logic [ST_W-1:0]  state_nxt;
   logic             tmr_load;
   logic [CNT_W-1:0] tmr_val;
   logic             tmr_dec;
   logic             tmr_zero;
   logic             accept_wr;
   logic             capture;

   logic ack_nxt, busy_nxt, write_nxt, read_nxt, pre_nxt, dvlp_nxt, sa_nxt;

   rram_phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (CLK),
      .rst      (RST),
      .load     (tmr_load),
      .load_val (tmr_val),
      .dec      (tmr_dec),
      .zero     (tmr_zero)
   );

   // State register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and timer control. Every phase exit reloads the timer with
   // the length of the phase being entered.
   always_comb begin
      state_nxt = state;
      tmr_load  = 1'b0;
      tmr_val   = '0;
      tmr_dec   = 1'b0;
      case (state)
         S_IDLE: begin
            if (REQ) begin
               tmr_load = 1'b1;
               if (WE) begin
                  state_nxt = S_WRITE;
                  tmr_val   = LD_WRITE;
               end else begin
                  state_nxt = S_PRE;
                  tmr_val   = LD_PRE;
               end
            end
         end
         S_PRE: begin
            if (tmr_zero) begin
               state_nxt = S_DVLP;
               tmr_load  = 1'b1;
               tmr_val   = LD_DVLP;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         S_DVLP: begin
            if (tmr_zero) begin
               state_nxt = S_SENSE;
               tmr_load  = 1'b1;
               tmr_val   = LD_SA;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         S_SENSE: begin
            if (tmr_zero) begin
               state_nxt = S_DONE;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         S_WRITE: begin
            if (tmr_zero) begin
               state_nxt = S_DONE;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign accept_wr = (state == S_IDLE) && REQ && WE;
   // Last SENSE cycle: SA_EN_H is still high, so Z_BUS is being driven.
   assign capture   = (state == S_SENSE) && tmr_zero;

   // Output decode from the next state, so every control line comes straight
   // off a flop and changes exactly on the state transition edge.
   always_comb begin
      ack_nxt   = (state_nxt == S_DONE);
      busy_nxt  = (state_nxt != S_IDLE);
      write_nxt = (state_nxt == S_WRITE);
      pre_nxt   = (state_nxt == S_PRE);
      dvlp_nxt  = (state_nxt == S_DVLP);
      sa_nxt    = (state_nxt == S_SENSE);
      read_nxt  = pre_nxt | dvlp_nxt | sa_nxt;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ACK        <= 1'b0;
         BUSY       <= 1'b0;
         WRITE_VDDH <= 1'b0;
         READ_VDDH  <= 1'b0;
         PRE_H      <= 1'b0;
         DVLP_H     <= 1'b0;
         SA_EN_H    <= 1'b0;
         dummy_en   <= 1'b0;
         WDATA      <= '0;
         DOUT       <= '0;
      end else begin
         ACK        <= ack_nxt;
         BUSY       <= busy_nxt;
         WRITE_VDDH <= write_nxt;
         READ_VDDH  <= read_nxt;
         PRE_H      <= pre_nxt;
         DVLP_H     <= dvlp_nxt;
         SA_EN_H    <= sa_nxt;
         dummy_en   <= busy_nxt;
         if (accept_wr) begin
            WDATA <= DIN;
         end
         if (capture) begin
            DOUT <= Z_BUS;
         end
      end
   end

endmodule

// File: tb/tb_rram_access_sequencer.sv
// tb/tb_rram_access_sequencer.sv - self-checking bench for rram_access_sequencer
module tb_rram_access_sequencer;

   logic       clk;
   logic       rst;
   logic       req [2];
   logic       we;
   logic [3:0] din;
   logic [3:0] zbus;

   logic [3:0] wd [2];
   logic [3:0] dq [2];
   logic [7:0] ctl [2];

   logic ack0, busy0, wr0, rd0, pre0, dv0, sa0, dm0;
   logic ack1, busy1, wr1, rd1, pre1, dv1, sa1, dm1;

   int checks = 0;
   int errors = 0;
   logic [3:0] exp_wd [2];
   logic [3:0] exp_dq [2];

   rram_access_sequencer dut0 (
      .CLK(clk), .RST(rst), .REQ(req[0]), .WE(we), .DIN(din), .Z_BUS(zbus),
      .WDATA(wd[0]), .DOUT(dq[0]), .ACK(ack0), .BUSY(busy0),
      .WRITE_VDDH(wr0), .READ_VDDH(rd0), .PRE_H(pre0), .DVLP_H(dv0),
      .SA_EN_H(sa0), .dummy_en(dm0)
   );

   rram_access_sequencer #(.T_PRE(1), .T_DVLP(1), .T_SA(1), .T_WRITE(1)) dut1 (
      .CLK(clk), .RST(rst), .REQ(req[1]), .WE(we), .DIN(din), .Z_BUS(zbus),
      .WDATA(wd[1]), .DOUT(dq[1]), .ACK(ack1), .BUSY(busy1),
      .WRITE_VDDH(wr1), .READ_VDDH(rd1), .PRE_H(pre1), .DVLP_H(dv1),
      .SA_EN_H(sa1), .dummy_en(dm1)
   );

   assign ctl[0] = {ack0, busy0, wr0, rd0, pre0, dv0, sa0, dm0};
   assign ctl[1] = {ack1, busy1, wr1, rd1, pre1, dv1, sa1, dm1};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One access on instance sel, starting at a negedge in IDLE. The expected
   // waveform is derived from phase lengths: cycle k after the accepting edge.
   task automatic run_access(input int sel, input logic w, input logic [3:0] d,
                             input logic [3:0] zv, input bit hold, input bit noise);
      int tp, td, ts, tw, s_end, lat;
      logic e_pre, e_dv, e_sa, e_wr, e_ack, e_busy;
      logic [7:0] e;
      tp = (sel == 1) ? 1 : 2;
      td = (sel == 1) ? 1 : 3;
      ts = (sel == 1) ? 1 : 2;
      tw = (sel == 1) ? 1 : 8;
      s_end = tp + td + ts;
      lat   = w ? tw + 1 : s_end + 1;
      we = w;
      din = d;
      req[sel] = 1'b1;
      for (int k = 1; k <= lat + 1; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == 1 && w) exp_wd[sel] = d;
         if (!w && k == s_end + 1) exp_dq[sel] = zv;
         e_pre  = !w && (k <= tp);
         e_dv   = !w && (k > tp) && (k <= tp + td);
         e_sa   = !w && (k > tp + td) && (k <= s_end);
         e_wr   = w && (k <= tw);
         e_ack  = (k == lat);
         e_busy = (k <= lat);
         e = {e_ack, e_busy, e_wr, e_pre | e_dv | e_sa, e_pre, e_dv, e_sa, e_busy};
         chk($sformatf("ctl%0d_k%0d", sel, k), ctl[sel], e);
         chk($sformatf("wdata%0d_k%0d", sel, k), wd[sel], exp_wd[sel]);
         chk($sformatf("dout%0d_k%0d", sel, k), dq[sel], exp_dq[sel]);
         chk($sformatf("excl%0d_k%0d", sel, k), $countones(ctl[sel][3:1]) <= 1, 1);
         if (k <= lat) begin
            req[sel] = hold ? 1'b1 : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
            we  = 1'($urandom_range(0, 1));
            din = 4'($urandom);
         end
         zbus = (!w && k > tp + td && k <= s_end) ? zv : 4'($urandom);
      end
      req[sel] = hold;
   endtask

   initial begin
      logic [3:0] d, z;
      rst = 1'b1;
      req[0] = 1'b0;
      req[1] = 1'b0;
      we = 1'b0;
      din = 4'h0;
      zbus = 4'h0;
      exp_wd[0] = 4'h0; exp_wd[1] = 4'h0;
      exp_dq[0] = 4'h0; exp_dq[1] = 4'h0;

      // Reset applied before any clock edge
      #1;
      chk("rst_ctl0", ctl[0], 8'h00);
      chk("rst_wd0", wd[0], 4'h0);
      chk("rst_dq0", dq[0], 4'h0);
      chk("rst_ctl1", ctl[1], 8'h00);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_ctl0", ctl[0], 8'h00);

      // Directed: read with Z_BUS=A, write 5, back-to-back with REQ held high
      run_access(0, 1'b0, 4'h3, 4'hA, 1'b0, 1'b0);
      run_access(0, 1'b1, 4'h5, 4'h0, 1'b0, 1'b0);
      run_access(0, 1'b1, 4'hC, 4'h0, 1'b1, 1'b0);
      run_access(0, 1'b0, 4'h0, 4'h6, 1'b1, 1'b1);
      run_access(0, 1'b0, 4'h0, 4'h9, 1'b0, 1'b1);

      // Asynchronous reset during DVLP abandons the read
      req[0] = 1'b1;
      we = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req[0] = 1'b0;
      repeat (2) @(negedge clk);
      chk("pre_rst_dvlp", dv0, 1'b1);
      chk("pre_rst_read", rd0, 1'b1);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_ctl", ctl[0], 8'h00);
      chk("mid_rst_wd", wd[0], 4'h0);
      chk("mid_rst_dq", dq[0], 4'h0);
      exp_wd[0] = 4'h0;
      exp_dq[0] = 4'h0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk($sformatf("post_rst_idle%0d", i), ctl[0], 8'h00);
      end
      run_access(0, 1'b0, 4'h0, 4'h7, 1'b0, 1'b0);

      // Randomized accesses against the phase-length model
      for (int i = 0; i < 20; i++) begin
         d = 4'($urandom);
         z = 4'($urandom);
         run_access(0, 1'($urandom_range(0, 1)), d, z,
                    bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      end
      req[0] = 1'b0;

      // Single-cycle phase corner
      run_access(1, 1'b0, 4'h0, 4'hE, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         d = 4'($urandom);
         z = 4'($urandom);
         run_access(1, 1'($urandom_range(0, 1)), d, z,
                    bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      end
      req[1] = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rram_access_sequencer.md
Name: rram_access_sequencer

Overview:
- Digital-domain (VDDH) controller for the RRAM column periphery; it generates the signals that the VDDL level-down and sense-amp block consumes.
- Drives WRITE_VDDH, READ_VDDH, PRE_H, DVLP_H, SA_EN_H and dummy_en.
- Sequences each read through precharge, develop and sense phases, then captures the sense-amp data that appears on Z_BUS.
- Sequences each write as a single timed WRITE pulse. Exposes a one-request-at-a-time REQ/ACK handshake to the upstream memory controller.

Parameters:
- B_SIZE, 4, data width; matches the Z_BUS width of the periphery.
- T_PRE, 2, precharge phase length in CLK cycles; must be >=1.
- T_DVLP, 3, bitline develop phase length in cycles; must be >=1.
- T_SA, 2, sense-amp enable phase length in cycles; must be >=1.
- T_WRITE, 8, write pulse length in cycles; must be >=1.
- CNT_W, 4, phase counter width; must satisfy 2^CNT_W >= max(T_*).

Ports:
- CLK  input  1  single system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- REQ  input  1  access request; sampled only when BUSY=0.
- WE  input  1  1=write, 0=read; sampled with REQ.
- DIN  input  B_SIZE  write data; sampled with REQ.
- Z_BUS  input  B_SIZE  sense-amp data from the periphery tristate bus.
- WDATA  output  B_SIZE  registered write data for the write drivers.
- DOUT  output  B_SIZE  read data; valid from ACK until the next accepted read.
- ACK  output  1  one-cycle completion pulse.
- BUSY  output  1  high from the cycle after acceptance through the ACK cycle.
- WRITE_VDDH  output  1  write pulse.
- READ_VDDH  output  1  read window.
- PRE_H  output  1  precharge enable.
- DVLP_H  output  1  develop enable.
- SA_EN_H  output  1  sense-amp enable; also enables the bus tristate downstream.
- dummy_en  output  1  level-shifter enable; high in every non-IDLE state.

Behaviour:
- All outputs are registered. RST forces state to IDLE and every output to 0 (DOUT and WDATA included) immediately, independent of CLK.
- Reset mid-operation abandons the access. No ACK is produced and no control line glitches high.
- States: IDLE, PRE, DVLP, SENSE, WRITE, DONE. Encodings are one-hot.
- IDLE:
  - If REQ=1 on a rising edge, latch WE and DIN, load WDATA<=DIN (writes only) and set BUSY=1.
  - Next state is PRE (WE=0) or WRITE (WE=1).
  - The phase counter loads T_x-1.
- Each timed state decrements the counter. When the counter is 0, the next edge advances to the following state and reloads the counter for that state.
- Read path, with outputs high during each state:
  - PRE: READ_VDDH and PRE_H.
  - DVLP: READ_VDDH and DVLP_H.
  - SENSE: READ_VDDH and SA_EN_H.
  - DONE: ACK only; no array control lines are high.
- PRE_H, DVLP_H and SA_EN_H are mutually exclusive in every cycle.
- READ_VDDH stays continuous across PRE through SENSE.
- DOUT <= Z_BUS on the edge that leaves SENSE. This is the last cycle SA_EN_H is high, so Z_BUS is driven when captured.
- Write path: WRITE lasts exactly T_WRITE cycles with WRITE_VDDH=1, then goes to DONE. READ_VDDH, PRE_H, DVLP_H and SA_EN_H stay 0 throughout a write.
- DONE: ACK=1 for exactly one cycle, then IDLE. BUSY falls with the IDLE entry.
- Latency from the accepting edge to the ACK cycle start:
  - read = T_PRE+T_DVLP+T_SA+1 cycles (8 with defaults);
  - write = T_WRITE+1 cycles (9 with defaults).
- REQ while BUSY=1 (including the DONE cycle) is ignored and not queued. REQ held high continuously starts a new access on the first IDLE edge.
- WE/DIN changes after acceptance have no effect.
- dummy_en = 1 in PRE, DVLP, SENSE, WRITE and DONE; 0 in IDLE.
- WDATA holds its last write value across reads. DOUT holds its last read value across writes.
- Counter width rule: T_*-1 must fit in CNT_W bits. Violations are a static configuration error, checked by an elaboration-time assertion.

Decomposition:
- The shared package rram_seq_pkg holds:
  - the state one-hot localparams (S_IDLE..S_DONE);
  - default phase lengths.
- One natural sub-module: rram_phase_timer, a CNT_W-bit loadable down-counter with load value, decrement enable and zero flag. The FSM and output registers stay in the top.

Test Plan:
- Reset/idle: assert RST mid-cycle with no clock -> all outputs 0 immediately; release -> IDLE, BUSY=0, dummy_en=0.
- Read with defaults, Z_BUS=4'hA during SENSE:
  - PRE_H high 2 cycles, DVLP_H 3, SA_EN_H 2; READ_VDDH high 7 continuous cycles;
  - ACK 8 cycles after acceptance; DOUT=4'hA; no two of PRE_H/DVLP_H/SA_EN_H ever high together.
- Write DIN=4'h5, WE=1 -> WDATA=4'h5 from the cycle after acceptance; WRITE_VDDH high exactly 8 cycles; ACK at cycle 9; READ_VDDH and SA_EN_H stay 0.
- Back-to-back: REQ held high with a write then a read -> second access accepted on the first IDLE edge after ACK; REQ pulses during BUSY produce no extra ACK.
- Reset mid-read: assert RST during DVLP -> DVLP_H/READ_VDDH drop asynchronously; no ACK; the next read completes normally with fresh DOUT.
- Parameter corner: T_PRE=T_DVLP=T_SA=1 -> each phase lasts exactly 1 cycle; ACK at cycle 4; DOUT captured correctly.
